data_memory_sync: RTL and testbench
===================================

DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning number of words; it need not be a power of two.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, meaning width of the byte address bus.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero every word after reset and 0 = skip clearing.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports below.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 reqValid  input  1  request present.
REQ-009 reqReady  output  1  block can accept a request this cycle.
REQ-010 regWE  input  1  1 = write request, 0 = read request.
REQ-011 byteEn  input  DATA_WIDTH/8  per-byte write strobe; byteEn[i] covers DataIn[8i+7:8i].
REQ-012 Addr  input  ADDR_WIDTH  byte address.
REQ-013 DataIn  input  DATA_WIDTH  write data.
REQ-014 rspValid  output  1  single-cycle response pulse.
REQ-015 DataOut  output  DATA_WIDTH  read data, valid while rspValid=1.
REQ-016 rspErr  output  1  response is an error, valid while rspValid=1.

Function
REQ-017 The block SHALL implement a two-state machine: CLEAR and IDLE.
REQ-018 A request SHALL be accepted on a rising clk edge where reqValid=1 and reqReady=1.
REQ-019 reqReady SHALL be 0 in CLEAR and 1 in IDLE; in CLEAR, reqValid is ignored.
REQ-020 In CLEAR, the block SHALL write zero to mem[clearIdx] each cycle, with clearIdx counting 0 to DEPTH-1; after writing DEPTH-1 it SHALL move to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-021 Word index SHALL be Addr >> log2(DATA_WIDTH/8).
REQ-022 A request SHALL be an error if its low log2(DATA_WIDTH/8) address bits are nonzero (misaligned) or if the word index is >= DEPTH.
REQ-023 An accepted valid write SHALL update only the byte lanes whose byteEn bit is 1; other lanes keep their value.
REQ-024 A write with byteEn all zero SHALL leave memory unchanged and SHALL still produce a non-error response.
REQ-025 An accepted valid read SHALL return mem[index] as sampled at the accept edge, with rspValid=1 and rspErr=0 in the next cycle (one-cycle latency).
REQ-026 An accepted write SHALL produce rspValid=1 in the next cycle with DataOut=0.
REQ-027 An accepted error request SHALL not modify memory and SHALL produce rspValid=1, rspErr=1, DataOut=0 in the next cycle.
REQ-028 The block SHALL accept a request every cycle with no bubbles; responses SHALL be returned in request order.
REQ-029 A read accepted one cycle after a write to the same word SHALL return the newly written data.
REQ-030 rspValid SHALL be 0 in every cycle that does not follow an accept; DataOut and rspErr SHALL hold their last value while rspValid=0.
REQ-031 There is no response backpressure: the consumer SHALL sample the response in the rspValid cycle.

Reset
REQ-032 On reset_n=0, asynchronously: state = CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; clearIdx=0; reqReady=0; rspValid=0; DataOut=0; rspErr=0.
REQ-033 reqReady SHALL rise no earlier than the first rising clk edge after reset_n deasserts.
REQ-034 Reset asserted mid-CLEAR SHALL restart clearing from index 0.
REQ-035 Reset asserted with a request in flight SHALL drop that response, so no rspValid pulse occurs.
REQ-036 With CLEAR_ON_RESET=0, memory contents SHALL survive reset.

Verification
REQ-037 Scenario: DEPTH=16, CLEAR_ON_RESET=1, release reset -> reqReady=0 for 16 cycles then 1; reads of all 16 words -> DataOut=0, rspErr=0.
REQ-038 Scenario: write 0xAABBCCDD to Addr 0x8 with byteEn=1111, then write 0x11223344 to Addr 0x8 with byteEn=0101, then read Addr 0x8 -> DataOut=0xAA22CC44.
REQ-039 Scenario: back-to-back write 0x12345678 to Addr 0x4 then read Addr 0x4 on consecutive cycles -> the read response next cycle is 0x12345678; rspValid is high on 2 consecutive cycles.
REQ-040 Scenario: read Addr 0x6 (misaligned) and read Addr 4*DEPTH (out of range) -> rspErr=1, DataOut=0 on both; a following read of a valid word shows its contents unchanged.
REQ-041 Scenario: assert reset_n=0 at cycle 5 of CLEAR, release -> CLEAR lasts the full DEPTH cycles again from index 0.
REQ-042 Scenario: accept a read, then assert reset before the response cycle -> no rspValid pulse; all outputs are 0.

Source files
------------

// File: rtl/data_memory_sync.sv
// data_memory_sync: single-port word memory with byte-lane writes and a
// one-cycle registered response. After reset it can optionally sweep every
// word to zero before it starts accepting requests.
module data_memory_sync #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    regWE,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [ADDR_WIDTH-1:0]   Addr,
  input  logic [DATA_WIDTH-1:0]   DataIn,
  output logic                    rspValid,
  output logic [DATA_WIDTH-1:0]   DataOut,
  output logic                    rspErr
);

  // Bytes per word, and the number of low address bits that select a byte.
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;

  // Width of the internal word index; at least one bit even for DEPTH == 1.
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The range check is done one bit wider than either operand so that a
  // DEPTH that does not fit in the address bus still compares correctly.
  localparam int CMPW = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [CMPW-1:0]       DEPTH_W   = CMPW'(DEPTH);
  localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Without clearing the block comes out of reset directly in IDLE, and the
  // memory keeps whatever it held before reset.
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  // Control state.
  state_e          state_q, state_d;
  logic [IDXW-1:0] clearIdx_q, clearIdx_d;
  logic            ready_q, ready_d;
  logic            clearWe;

  // Response registers.
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  rspErr_q, rspErr_d;

  // Storage. Deliberately not reset: clearing is done by the CLEAR sweep so
  // that the array can map onto plain RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Request decode.
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic                  misaligned;
  logic                  outOfRange;
  logic                  reqErr;
  logic [IDXW-1:0]       memIdx;
  logic                  accept;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] rdData;

  // Split the byte address into word index and error flags, and qualify the
  // handshake. reqReady is a register, so nothing is accepted during reset
  // or during the clear sweep.
  always_comb begin
    wordAddr   = Addr >> OFFS;
    misaligned = |(Addr & OFFS_MASK);
    outOfRange = (CMPW'(wordAddr) >= DEPTH_W);
    reqErr     = misaligned | outOfRange;
    memIdx     = wordAddr[IDXW-1:0];
    accept     = reqValid & ready_q;
    memWe      = accept & regWE & ~reqErr;
    rdData     = mem_q[memIdx];
  end

  // Next-state logic: CLEAR walks clearIdx from 0 to DEPTH-1 writing one
  // zero word per cycle, then hands over to IDLE. ready_d is computed
  // alongside so reqReady rises on the same edge the state enters IDLE.
  always_comb begin
    state_d    = state_q;
    clearIdx_d = clearIdx_q;
    ready_d    = ready_q;
    clearWe    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearWe = 1'b1;
        ready_d = 1'b0;
        if (clearIdx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          clearIdx_d = '0;
          ready_d    = 1'b1;
        end else begin
          clearIdx_d = clearIdx_q + IDXW'(1);
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control registers; reset restarts the clear sweep from index 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      clearIdx_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearIdx_q <= clearIdx_d;
      ready_q    <= ready_d;
    end
  end

  // Memory array: the clear sweep owns the write port while it runs,
  // otherwise accepted legal writes update only their enabled byte lanes.
  always_ff @(posedge clk) begin
    if (clearWe) begin
      mem_q[clearIdx_q] <= '0;
    end else if (memWe) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteEn[b]) begin
          mem_q[memIdx][8*b +: 8] <= DataIn[8*b +: 8];
        end
      end
    end
  end

  // Response formation: errors and writes return zero data, reads return the
  // word as it stood before this edge's write. When nothing is accepted the
  // data and error flag hold their last value.
  always_comb begin
    rspValid_d = accept;
    dataOut_d  = dataOut_q;
    rspErr_d   = rspErr_q;
    if (accept) begin
      if (reqErr) begin
        rspErr_d  = 1'b1;
        dataOut_d = '0;
      end else if (regWE) begin
        rspErr_d  = 1'b0;
        dataOut_d = '0;
      end else begin
        rspErr_d  = 1'b0;
        dataOut_d = rdData;
      end
    end
  end

  // Response registers; an in-flight response is dropped by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rspValid_q <= 1'b0;
      dataOut_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      rspValid_q <= rspValid_d;
      dataOut_q  <= dataOut_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign reqReady = ready_q;
  assign rspValid = rspValid_q;
  assign DataOut  = dataOut_q;
  assign rspErr   = rspErr_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Testbench for data_memory_sync with a 16-word, 32-bit, clear-on-reset
// configuration. A behavioural model tracks memory contents and the expected
// response of every cycle; directed scenarios add literal expectations.
module tb_data_memory_sync;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reqValid;
  logic          reqReady;
  logic          regWE;
  logic [DW/8-1:0] byteEn;
  logic [AW-1:0] Addr;
  logic [DW-1:0] DataIn;
  logic          rspValid;
  logic [DW-1:0] DataOut;
  logic          rspErr;

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [31:0] modelMem [DEP];
  logic        modelReady = 1'b0;
  int          clearCnt   = 0;
  logic        expValid   = 1'b0;
  logic [31:0] expData    = '0;
  logic        expErr     = 1'b0;

  data_memory_sync #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEP),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .regWE   (regWE),
    .byteEn  (byteEn),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .rspValid(rspValid),
    .DataOut (DataOut),
    .rspErr  (rspErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model: the block is ready DEP edges after reset release; each accepted
  // request yields a response on the next cycle computed from the array.
  always @(posedge clk or negedge reset_n) begin
    logic        acc;
    logic        err;
    int          idx;
    int          newCnt;
    logic [31:0] word;
    if (!reset_n) begin
      modelReady <= 1'b0;
      clearCnt   <= 0;
      expValid   <= 1'b0;
      expData    <= '0;
      expErr     <= 1'b0;
      for (int i = 0; i < DEP; i++) modelMem[i] <= '0;
    end else begin
      acc    = reqValid && modelReady;
      newCnt = (clearCnt < DEP) ? clearCnt + 1 : clearCnt;
      clearCnt   <= newCnt;
      modelReady <= (newCnt >= DEP);
      expValid   <= acc;
      if (acc) begin
        err = (Addr[1:0] != 2'b00) || (Addr[31:2] >= 30'(DEP));
        idx = int'(Addr[31:2]);
        if (err) begin
          expErr  <= 1'b1;
          expData <= '0;
        end else if (regWE) begin
          word = modelMem[idx];
          for (int b = 0; b < 4; b++)
            if (byteEn[b]) word[8*b +: 8] = DataIn[8*b +: 8];
          modelMem[idx] <= word;
          expErr  <= 1'b0;
          expData <= '0;
        end else begin
          expErr  <= 1'b0;
          expData <= modelMem[idx];
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model_reqReady", {31'b0, reqReady}, {31'b0, modelReady});
    checkOutput("model_rspValid", {31'b0, rspValid}, {31'b0, expValid});
    checkOutput("model_DataOut", DataOut, expData);
    checkOutput("model_rspErr", {31'b0, rspErr}, {31'b0, expErr});
  end

  // Present one request for one cycle; returns at the negedge where its
  // response is visible.
  task automatic applyStimulus(input logic we, input logic [3:0] be,
                               input logic [31:0] a, input logic [31:0] d);
    reqValid = 1'b1;
    regWE    = we;
    byteEn   = be;
    Addr     = a;
    DataIn   = d;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    reqValid = 1'b0;
    regWE    = 1'b0;
    byteEn   = '0;
    @(negedge clk);
  endtask

  // Count rising edges until reqReady appears, bounded.
  task automatic waitForReady(input string name);
    int cnt;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (reqReady) break;
    end
    checkOutput(name, cnt, 32'd16);
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    reqValid = 1'b0;
    regWE    = 1'b0;
    byteEn   = '0;
    Addr     = '0;
    DataIn   = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("reset_reqReady", {31'b0, reqReady}, 32'd0);
    checkOutput("reset_rspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("reset_DataOut", DataOut, 32'd0);
    checkOutput("reset_rspErr", {31'b0, rspErr}, 32'd0);

    // Clear sweep length, then every word reads back zero.
    reset_n = 1'b1;
    waitForReady("clear_cycles");
    for (int i = 0; i < DEP; i++) begin
      applyStimulus(1'b0, 4'h0, 32'(i * 4), 32'h0);
      checkOutput("clear_read_valid", {31'b0, rspValid}, 32'd1);
      checkOutput("clear_read_data", DataOut, 32'd0);
      checkOutput("clear_read_err", {31'b0, rspErr}, 32'd0);
    end
    idleCycle();
    checkOutput("idle_no_rsp", {31'b0, rspValid}, 32'd0);

    // Byte-lane merge.
    applyStimulus(1'b1, 4'hF, 32'h8, 32'hAABBCCDD);
    checkOutput("wr_full_data", DataOut, 32'd0);
    applyStimulus(1'b1, 4'h5, 32'h8, 32'h11223344);
    applyStimulus(1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("merge_read", DataOut, 32'hAA22CC44);
    idleCycle();
    checkOutput("hold_data", DataOut, 32'hAA22CC44);

    // Back-to-back write then read of the same word.
    applyStimulus(1'b1, 4'hF, 32'h4, 32'h12345678);
    checkOutput("b2b_wr_valid", {31'b0, rspValid}, 32'd1);
    checkOutput("b2b_wr_data", DataOut, 32'd0);
    applyStimulus(1'b0, 4'h0, 32'h4, 32'h0);
    checkOutput("b2b_rd_valid", {31'b0, rspValid}, 32'd1);
    checkOutput("b2b_rd_data", DataOut, 32'h12345678);
    idleCycle();

    // Error requests, and a write with no lanes enabled.
    applyStimulus(1'b0, 4'h0, 32'h6, 32'h0);
    checkOutput("misaligned_err", {31'b0, rspErr}, 32'd1);
    checkOutput("misaligned_data", DataOut, 32'd0);
    applyStimulus(1'b0, 4'h0, 32'(4 * DEP), 32'h0);
    checkOutput("range_err", {31'b0, rspErr}, 32'd1);
    checkOutput("range_data", DataOut, 32'd0);
    applyStimulus(1'b1, 4'hF, 32'h9, 32'hFFFFFFFF);
    checkOutput("misaligned_wr_err", {31'b0, rspErr}, 32'd1);
    applyStimulus(1'b1, 4'hF, 32'(4 * DEP + 8), 32'hFFFFFFFF);
    checkOutput("range_wr_err", {31'b0, rspErr}, 32'd1);
    applyStimulus(1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
    checkOutput("zero_be_err", {31'b0, rspErr}, 32'd0);
    checkOutput("zero_be_valid", {31'b0, rspValid}, 32'd1);
    applyStimulus(1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("after_err_read", DataOut, 32'hAA22CC44);
    applyStimulus(1'b0, 4'h0, 32'(4 * (DEP - 1)), 32'h0);
    checkOutput("last_word_err", {31'b0, rspErr}, 32'd0);
    idleCycle();

    // Reset in the middle of the clear sweep restarts it from zero.
    pulseReset();
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midclear_reqReady", {31'b0, reqReady}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    waitForReady("reclear_cycles");
    applyStimulus(1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("reclear_read", DataOut, 32'd0);

    // Reset with a response in flight drops it.
    applyStimulus(1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("pre_drop_read", DataOut, 32'hCAFEF00D);
    reqValid = 1'b1;
    regWE    = 1'b0;
    Addr     = 32'h0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("drop_rspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("drop_DataOut", DataOut, 32'd0);
    checkOutput("drop_rspErr", {31'b0, rspErr}, 32'd0);
    checkOutput("drop_reqReady", {31'b0, reqReady}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
